raw_pattern_gen: RTL

//  Synthetic Bayer RAW video source driving the ISP input stream (vsync/hsync/den + 8-bit raw).

---
 rtl/raw_pattern_gen.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/raw_pattern_gen.sv
// Synthetic Bayer RGGB video source: full raster timing (active, porches, sync)
// with selectable test patterns, standing in for the sensor front end.
module raw_pattern_gen #(
    parameter int source_h = 1024,
    parameter int source_v = 1024,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 32,
    parameter int H_BP     = 48,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pattern_mode,
    output logic        out_vsync,
    output logic        out_hsync,
    output logic        out_den,
    output logic [7:0]  out_raw,
    output logic [15:0] frame_cnt,
    output logic        frame_done
);

    localparam int H_TOTAL = source_h + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = source_v + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = source_h / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0] H_ACT    = HW'(source_h);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_FIRST = HW'(source_h + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(source_h + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(source_v);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VS_FIRST = VW'(source_v + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(source_v + V_FP + V_SYNC - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state, state_n;
    logic [HW-1:0]   h, h_n;
    logic [VW-1:0]   v, v_n;
    logic [BW-1:0]   bar_pix, bar_pix_n;
    logic [2:0]      bar_idx, bar_idx_n;
    logic [1:0]      mode_lat, mode_n;
    logic [7:0]      fbase, fbase_n;
    logic [15:0]     fc_inc;
    logic            frame_end;
    logic            run;
    logic            den_c;
    logic            hsync_c;
    logic            vsync_c;
    logic [7:0]      raw_c;

    // Bar colour bits follow white, yellow, cyan, green, magenta, red, blue, black:
    // R is on for bars 0,1,4,5; G for 0..3; B for even bars.
    function automatic logic [7:0] pixel_value(
        input logic [1:0]    mode,
        input logic [HW-1:0] ph,
        input logic [VW-1:0] pv,
        input logic [2:0]    bar,
        input logic [7:0]    base
    );
        logic       r;
        logic       g;
        logic       b;
        logic       site;
        logic [7:0] pix;
        r = ~bar[1];
        g = ~bar[2];
        b = ~bar[0];
        case ({pv[0], ph[0]})
            2'b00:   site = r;
            2'b11:   site = b;
            default: site = g;
        endcase
        case (mode)
            2'd0:    pix = {8{site}};
            2'd1:    pix = 8'(ph);
            2'd2:    pix = 8'h80;
            default: pix = 8'(ph) + 8'(pv) + base;
        endcase
        return pix;
    endfunction

    assign run     = (state == RUN);
    assign fc_inc  = frame_cnt + 16'd1;
    assign den_c   = (h < H_ACT) && (v < V_ACT);
    assign hsync_c = (h >= HS_FIRST) && (h <= HS_LAST);
    assign vsync_c = (v >= VS_FIRST) && (v <= VS_LAST);
    assign raw_c   = pixel_value(mode_lat, h, v, bar_idx, fbase);

    always_comb begin
        state_n   = state;
        h_n       = h;
        v_n       = v;
        bar_pix_n = bar_pix;
        bar_idx_n = bar_idx;
        mode_n    = mode_lat;
        fbase_n   = fbase;
        frame_end = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_n   = RUN;
                    h_n       = '0;
                    v_n       = '0;
                    bar_pix_n = '0;
                    bar_idx_n = '0;
                    mode_n    = pattern_mode;
                    fbase_n   = frame_cnt[7:0];
                end
            end
            RUN: begin
                frame_end = (h == H_LAST) && (v == V_LAST);
                if (h == H_LAST) begin
                    h_n       = '0;
                    bar_pix_n = '0;
                    bar_idx_n = '0;
                    v_n       = (v == V_LAST) ? '0 : v + VW'(1);
                end else begin
                    h_n = h + HW'(1);
                    if (bar_pix == BAR_LAST) begin
                        bar_pix_n = '0;
                        bar_idx_n = bar_idx + 3'd1;
                    end else begin
                        bar_pix_n = bar_pix + BW'(1);
                    end
                end
                // The diagonal offset of the next frame uses the count as it
                // stands after this frame's increment.
                if (frame_end) begin
                    if (enable) begin
                        mode_n  = pattern_mode;
                        fbase_n = fc_inc[7:0];
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            h          <= '0;
            v          <= '0;
            bar_pix    <= '0;
            bar_idx    <= '0;
            mode_lat   <= '0;
            fbase      <= '0;
            out_den    <= 1'b0;
            out_hsync  <= 1'b0;
            out_vsync  <= 1'b0;
            out_raw    <= 8'h00;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_n;
            h          <= h_n;
            v          <= v_n;
            bar_pix    <= bar_pix_n;
            bar_idx    <= bar_idx_n;
            mode_lat   <= mode_n;
            fbase      <= fbase_n;
            // Outputs trail the raster counters by one clock.
            out_den    <= run && den_c;
            out_hsync  <= run && hsync_c;
            out_vsync  <= run && vsync_c;
            out_raw    <= (run && den_c) ? raw_c : 8'h00;
            frame_done <= frame_end;
            if (frame_end) begin
                frame_cnt <= fc_inc;
            end
        end
    end

endmodule
